// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, flags, and an iterative shift-add multiplier.
// Non-MUL ops have a latency of one cycle. MUL holds off new input for WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLTU = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic {IDLE, MUL_BUSY} state_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
  logic [TAG_W-1:0] mul_tag;

  op_e              op;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
  end

  always_comb begin
    op      = op_e'(in_op);
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    shamt   = in_b[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        // Bit WIDTH of the widened difference is the unsigned borrow.
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $signed(in_a) >>> shamt;
      default: ;
    endcase
  end

  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      mul_tag    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_tag    <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (op == OP_MUL) begin
              mcand   <= in_a;
              mplier  <= in_b;
              acc     <= '0;
              mul_tag <= in_tag;
              cnt     <= '0;
              state   <= MUL_BUSY;
            end else begin
              out_result <= alu_res;
              out_zero   <= (op <= OP_MUL) && (alu_res == '0);
              out_carry  <= alu_c;
              out_ovf    <= alu_v;
              out_tag    <= in_tag;
              out_valid  <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Output register is known free here: it was free when the MUL was accepted.
          if (cnt == CW'(WIDTH - 1)) begin
            out_result <= acc_nx;
            out_zero   <= (acc_nx == '0);
            out_carry  <= 1'b0;
            out_ovf    <= 1'b0;
            out_tag    <= mul_tag;
            out_valid  <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=32, TAG_W=5) with hand-computed expectations.
module tb_alu_pipe;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic          out_zero, out_carry, out_ovf;
  logic [TW-1:0] out_tag;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = t;
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] r, input logic z,
                            input logic c, input logic v, input logic [TW-1:0] t);
    check({nm, "_valid"}, out_valid, 1);
    check({nm, "_res"}, out_result, r);
    check({nm, "_zero"}, out_zero, z);
    check({nm, "_carry"}, out_carry, c);
    check({nm, "_ovf"}, out_ovf, v);
    check({nm, "_tag"}, out_tag, t);
  endtask

  task automatic wait_valid(output int lat, output logic rdy_seen);
    lat = 0; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        rdy_seen;
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [W+TW-1:0] exp_q [$];
    logic [W+TW-1:0] e;
    int          sent, rcvd;
    logic        stalled;
    logic [W-1:0]  held_r;
    logic [TW-1:0] held_t;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", {out_zero, out_carry, out_ovf}, 0);
    check("rst_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);

    issue(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd1);
    expect_out("add_wrap", 32'h0, 1, 1, 0, 5'd1);
    issue(4'd0, 32'h7FFF_FFFF, 32'h1, 5'd2);
    expect_out("add_ovf", 32'h8000_0000, 0, 0, 1, 5'd2);
    issue(4'd1, 32'h8000_0000, 32'h1, 5'd3);
    expect_out("sub_ovf", 32'h7FFF_FFFF, 0, 0, 1, 5'd3);
    issue(4'd1, 32'h1, 32'h2, 5'd4);
    expect_out("sub_borrow", 32'hFFFF_FFFF, 0, 1, 0, 5'd4);
    issue(4'd6, 32'hFFFF_FFFF, 32'h0, 5'd5);
    expect_out("slt", 32'h1, 0, 0, 0, 5'd5);
    issue(4'd5, 32'hFFFF_FFFF, 32'h0, 5'd6);
    expect_out("sltu", 32'h0, 1, 0, 0, 5'd6);
    issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
    expect_out("and", 32'hF000_F000, 0, 0, 0, 5'd7);
    issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8);
    expect_out("or", 32'hFFF0_FFF0, 0, 0, 0, 5'd8);
    issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9);
    expect_out("xor", 32'h0FF0_0FF0, 0, 0, 0, 5'd9);
    issue(4'd7, 32'h1, 32'h21, 5'd10);
    expect_out("sll", 32'h2, 0, 0, 0, 5'd10);
    issue(4'd9, 32'h8000_0000, 32'h24, 5'd11);
    expect_out("sra", 32'hF800_0000, 0, 0, 0, 5'd11);
    issue(4'd8, 32'h8000_0000, 32'h24, 5'd12);
    expect_out("srl", 32'h0800_0000, 0, 0, 0, 5'd12);
    issue(4'd13, 32'h5, 32'h6, 5'd13);
    check("op13_valid", out_valid, 1);
    check("op13_res", out_result, 0);
    check("op13_cv", {out_carry, out_ovf}, 0);
    check("op13_tag", out_tag, 13);

    issue(4'd10, 32'd12345, 32'd10, 5'd7);
    wait_valid(lat, rdy_seen);
    check("mul_latency", lat, 32);
    check("mul_ready_low", rdy_seen, 0);
    expect_out("mul", 32'h0001_E23A, 0, 0, 0, 5'd7);
    check("mul_ready_after", in_ready, 1);
    issue(4'd10, 32'hFFFF_FFFF, 32'd3, 5'd8);
    wait_valid(lat, rdy_seen);
    check("mul2_latency", lat, 32);
    expect_out("mul_wrap", 32'hFFFF_FFFD, 0, 0, 0, 5'd8);
    @(posedge clk); #1;
    check("idle_before_stream", out_valid, 0);

    sent = 0; rcvd = 0; stalled = 1'b0; held_r = '0; held_t = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = pat[cyc % 4];
      in_valid = 1'b1; in_op = 4'd0;
      in_a = 32'h100 + W'(sent); in_b = 32'h1000; in_tag = TW'(sent);
      @(negedge clk);
      if (stalled) begin
        check("hold_res", out_result, held_r);
        check("hold_tag", out_tag, held_t);
      end
      if (out_valid) check("ready_mirror", in_ready, out_ready);
      else check("ready_empty", in_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stream_dup", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("stream_res_tag", {out_result, out_tag}, e);
        end
        rcvd++;
      end
      if (in_ready) begin
        exp_q.push_back({32'h1100 + W'(sent), TW'(sent)});
        sent++;
      end
      stalled = out_valid && !out_ready;
      held_r = out_result; held_t = out_tag;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
      @(negedge clk);
      if (out_valid) begin
        e = exp_q.pop_front();
        check("drain_res_tag", {out_result, out_tag}, e);
        rcvd++;
      end
      @(posedge clk); #1;
    end
    check("stream_all_received", exp_q.size(), 0);
    check("stream_count", rcvd, sent);
    check("stream_idle", out_valid, 0);

    issue(4'd10, 32'd3, 32'd4, 5'd9);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mul_valid", out_valid, 0);
    check("rst_mul_in_ready", in_ready, 1);
    check("rst_mul_res_tag", {out_result, out_tag}, 0);
    issue(4'd0, 32'd2, 32'd3, 5'd10);
    expect_out("add_after_rst", 32'd5, 0, 0, 0, 5'd10);
    @(posedge clk); #1;
    rdy_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) rdy_seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mul_discarded", rdy_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
